// File: rtl/denise_palette_writer.sv
// rtl/denise_palette_writer.sv - paced colour-palette loader for the Denise colour registers
//
// Accepts a stream of 12-bit colour words through a small FIFO and writes them,
// one per 7MHz clock-enable period, to consecutive colour registers starting at
// COLORBASE + 2*first_index.
//
// Optional feature macro: DENISE_PALETTE_WRAP_EN
//   defined   : the register index wraps 31 -> 0 and all count words are written
//   undefined : the write to index 31 ends the load
//
// Ports:
//   clk             28MHz clock
//   reset_n         asynchronous active-low reset
//   clk7_en         7MHz clock enable, paces register writes
//   start           single-cycle load request (ignored while busy)
//   abort           single-cycle cancel, wins over start
//   first_index     first colour register number
//   count           number of colour words (clamped to 32)
//   wr_valid        colour word present on wr_data
//   wr_data         colour word {R,G,B} 4 bits each
//   wr_ready        word accepted when wr_valid and wr_ready are high
//   busy            load in progress (RUN or DONE)
//   done            one-clk pulse when a load completes
//   reg_address_out register address bits [8:1], 8'hFF when idle
//   data_out        register write data
module denise_palette_writer #(
    parameter logic [8:0] COLORBASE  = 9'h180,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  first_index,
    input  logic [5:0]  count,
    input  logic        wr_valid,
    input  logic [11:0] wr_data,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  reg_address_out,
    output logic [11:0] data_out
);

    localparam int          AW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  IDLE_ADDR = 8'hFF;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [11:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_fill;
    logic [4:0]     r_index;
    logic [5:0]     r_limit;
    logic [5:0]     r_accepted;
    logic [5:0]     r_written;
    logic [7:0]     r_addr;
    logic [11:0]    r_data;

    logic [5:0]     w_count_clamped;
    logic [5:0]     w_room;
    logic [5:0]     w_limit;
    logic           w_full;
    logic           w_empty;
    logic           w_ready;
    logic           w_push;
    logic           w_pop;
    logic           w_last;
    logic           w_load;

    // Number of words this load will actually write; without wrap the run
    // stops at register 31, so the limit is also bounded by the room left.
    always_comb begin
        w_count_clamped = (count > 6'd32) ? 6'd32 : count;
        w_room          = 6'd32 - {1'b0, first_index};
`ifdef DENISE_PALETTE_WRAP_EN
        w_limit         = w_count_clamped;
`else
        w_limit         = (w_count_clamped < w_room) ? w_count_clamped : w_room;
`endif
    end

    always_comb begin
        w_full  = (r_fill == FULL_LVL);
        w_empty = (r_fill == '0);
        w_ready = (r_state == RUN) && !w_full && (r_accepted < r_limit) && !abort;
        w_push  = wr_valid && w_ready;
        w_pop   = (r_state == RUN) && clk7_en && !w_empty && !abort;
        w_last  = w_pop && ((r_written + 6'd1) == r_limit);
        w_load  = (r_state == IDLE) && start && !abort;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_load) w_next = (w_count_clamped == 6'd0) ? DONE : RUN;
            RUN: begin
                if (abort)       w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // FIFO storage carries no reset; validity is tracked by r_fill alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fill     <= '0;
            r_index    <= 5'd0;
            r_limit    <= 6'd0;
            r_accepted <= 6'd0;
            r_written  <= 6'd0;
            r_addr     <= IDLE_ADDR;
            r_data     <= 12'h000;
        end else begin
            if (w_load) begin
                r_index    <= first_index;
                r_limit    <= w_limit;
                r_accepted <= 6'd0;
                r_written  <= 6'd0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_fill     <= '0;
            end else if (abort) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_fill <= '0;
            end else begin
                if (w_push) begin
                    r_wptr     <= r_wptr + AW'(1);
                    r_accepted <= r_accepted + 6'd1;
                end
                if (w_pop) begin
                    r_rptr    <= r_rptr + AW'(1);
                    r_index   <= r_index + 5'd1;
                    r_written <= r_written + 6'd1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_fill <= r_fill + (AW+1)'(1);
                    2'b01:   r_fill <= r_fill - (AW+1)'(1);
                    default: r_fill <= r_fill;
                endcase
            end

            // A write occupies exactly one clk7 period; any clk7 edge
            // without a word to write (idle, done, after abort) parks the
            // address on the NO-OP register while the data holds.
            if (clk7_en) begin
                if (w_pop) begin
                    r_addr <= {COLORBASE[8:6], r_index};
                    r_data <= r_mem[r_rptr];
                end else begin
                    r_addr <= IDLE_ADDR;
                end
            end
        end
    end

    assign wr_ready        = w_ready;
    assign busy            = (r_state != IDLE);
    assign done            = (r_state == DONE);
    assign reg_address_out = r_addr;
    assign data_out        = r_data;

endmodule

// File: tb/tb_denise_palette_writer.sv
// tb/tb_denise_palette_writer.sv - scoreboard bench for denise_palette_writer
module tb_denise_palette_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk7_en = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  first_index = 5'd0;
    logic [5:0]  count = 6'd0;
    logic        wr_valid = 1'b0;
    logic [11:0] wr_data = 12'h000;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic [7:0]  reg_address_out;
    logic [11:0] data_out;

    denise_palette_writer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clk7_en         (clk7_en),
        .start           (start),
        .abort           (abort),
        .first_index     (first_index),
        .count           (count),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .busy            (busy),
        .done            (done),
        .reg_address_out (reg_address_out),
        .data_out        (data_out)
    );

    always #5 clk = ~clk;

    int c7_div = 0;
    always @(negedge clk) begin
        c7_div  = (c7_div + 1) % 4;
        clk7_en = (c7_div == 0);
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [19:0] sb [$];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          stall_cnt = 0;
    bit          rdy_seen = 1'b0;
    logic [7:0]  last_addr = 8'hFF;
    logic [11:0] words_tbl [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: a register write is a non-idle address appearing just
    // after a clk7_en edge.
    always @(posedge clk) begin
        bit c7;
        c7 = clk7_en;
        #1;
        if (reset_n && c7 && reg_address_out != 8'hFF) begin
            wr_cnt++;
            last_addr = reg_address_out;
            chk("write_expected", sb.size() > 0, 1);
            if (sb.size() > 0) chk("write_addr_data", {reg_address_out, data_out}, sb.pop_front());
        end
        if (done) done_cnt++;
        if (wr_ready) rdy_seen = 1'b1;
    end

    task automatic send_word(input logic [11:0] d, input logic [7:0] addr);
        bit ok = 1'b0;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int t = 0; t < 200 && !ok; t++) begin
            #1;
            if (wr_ready) begin
                sb.push_back({addr, d});
                ok = 1'b1;
            end else begin
                stall_cnt++;
            end
            @(negedge clk);
        end
        chk("send_timeout", ok, 1);
    endtask

    task automatic do_start(input logic [4:0] fi, input logic [5:0] cnt);
        start = 1'b1;
        first_index = fi;
        count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input logic [4:0] fi, input logic [5:0] cnt, input int nsend,
                            input int exp_writes, input bit fixed);
        int w0 = wr_cnt;
        int d0 = done_cnt;
        logic [4:0] idx = fi;
        bit seen = 1'b0;
        do_start(fi, cnt);
        for (int i = 0; i < nsend; i++) begin
            logic [11:0] d;
            d = (fixed && i < 4) ? words_tbl[i] : 12'($urandom);
            send_word(d, {3'b110, idx});
            idx++;
        end
        if (nsend < int'(cnt)) begin
            for (int i = 0; i < 4; i++) begin
                #1;
                chk("ready_low_at_limit", wr_ready, 0);
                @(negedge clk);
            end
        end
        wr_valid = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", seen, 1);
        chk("final_write_held", reg_address_out, last_addr);
        @(negedge clk);
        chk("done_one_clk", done, 0);
        chk("busy_after_done", busy, 0);
        for (int t = 0; t < 8 && reg_address_out != 8'hFF; t++) @(negedge clk);
        chk("idle_addr", reg_address_out, 8'hFF);
        chk("write_count", wr_cnt - w0, exp_writes);
        chk("done_pulses", done_cnt - d0, 1);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic wait_two_writes(input int w0);
        for (int t = 0; t < 200 && (wr_cnt - w0) < 2; t++) @(negedge clk);
        chk("two_writes", (wr_cnt - w0) >= 2, 1);
    endtask

    initial begin
        int w0;
        int d0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr", reg_address_out, 8'hFF);
        chk("rst_data", data_out, 12'h000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", wr_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Four fixed words from index 0.
        run_load(5'd0, 6'd4, 4, 4, 1'b1);
        chk("last_addr_0x186", {last_addr, 1'b0}, 9'h186);

        // count == 0: immediate done, no writes, wr_ready never high.
        rdy_seen = 1'b0;
        w0 = wr_cnt;
        do_start(5'd3, 6'd0);
        #1;
        chk("cnt0_done", done, 1);
        chk("cnt0_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("cnt0_done_end", done, 0);
        chk("cnt0_busy_end", busy, 0);
        chk("cnt0_ready_never", rdy_seen, 0);
        chk("cnt0_no_writes", wr_cnt - w0, 0);
        @(negedge clk);

        // Index 31 boundary.
`ifdef DENISE_PALETTE_WRAP_EN
        run_load(5'd30, 6'd4, 4, 4, 1'b0);
        chk("wrap_last_addr", {last_addr, 1'b0}, 9'h182);
`else
        run_load(5'd30, 6'd4, 2, 2, 1'b0);
        chk("nowrap_last_addr", {last_addr, 1'b0}, 9'h1BE);
`endif

        // Back-pressure: 32 words with wr_valid held, count 40 clamps to 32.
        stall_cnt = 0;
        run_load(5'd0, 6'd40, 32, 32, 1'b0);
        chk("ready_dropped_full", stall_cnt > 0, 1);

        // start and abort together: abort wins.
        abort = 1'b1;
        do_start(5'd0, 6'd4);
        abort = 1'b0;
        #1;
        chk("start_abort_idle", busy, 0);
        @(negedge clk);

        // Abort after two writes.
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(5'd0, 6'd8);
        for (int i = 0; i < 4; i++) send_word(12'($urandom), {3'b110, 5'(i)});
        wr_valid = 1'b0;
        wait_two_writes(w0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", wr_ready, 0);
        for (int t = 0; t < 5 && reg_address_out != 8'hFF; t++) @(negedge clk);
        chk("abort_idle_addr", reg_address_out, 8'hFF);
        repeat (16) @(negedge clk);
        chk("abort_writes", wr_cnt - w0, 2);
        chk("abort_no_done", done_cnt - d0, 0);

        // Reset mid-load.
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(5'd4, 6'd8);
        for (int i = 0; i < 4; i++) send_word(12'($urandom), {3'b110, 5'(4 + i)});
        wr_valid = 1'b0;
        wait_two_writes(w0);
        reset_n = 1'b0;
        #1;
        chk("rstrun_addr", reg_address_out, 8'hFF);
        chk("rstrun_data", data_out, 12'h000);
        chk("rstrun_busy", busy, 0);
        chk("rstrun_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        repeat (16) @(negedge clk);
        chk("rstrun_writes", wr_cnt - w0, 2);
        chk("rstrun_no_done", done_cnt - d0, 0);
        chk("rstrun_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
